// File: rtl/byte_serial_logic_unit.sv
// byte_serial_logic_unit
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR) for the ALU path.
// Evaluates one 8-bit lane per clock, LSB lane first, then holds the
// assembled result and zero flag until the consumer takes them.

module byte_serial_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int LANES = WIDTH / 8;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  // One lane of the selected bitwise operation; lanes never interact.
  function automatic logic [7:0] lane_op(input logic [1:0] op_sel,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
    logic [7:0] r;
    case (op_sel)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  // Next-state logic: accept in IDLE, one lane per RUN cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          cnt_d    = '0;
          result_d = '0;
          zero_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < LANES; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            result_d[8*k +: 8] = lane_op(op_q, a_q[8*k +: 8], b_q[8*k +: 8]);
          end
        end
        if (cnt_q == CNT_W'(LANES - 1)) begin
          zero_d  = (result_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
